// File: rtl/rtc_bus_master.sv
// Bus engine for the RTC multiplexed address/data bus: host read/write transactions with
// programmable strobe timing, plus refresh bursts that copy a list of RTC registers into a shadow file.
module rtc_bus_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int N_REGS = 9,
    parameter logic [N_REGS*ADDR_W-1:0] ADDR_LIST = 72'h41_42_43_21_22_23_24_25_26,
    parameter int T_SETUP = 1,
    parameter int T_PULSE = 2,
    parameter int T_HOLD = 1,
    localparam int SEL_W = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              refresh_start,
    input  logic              irq,
    input  logic              irq_refresh_en,
    output logic              refresh_busy,
    output logic              refresh_done,
    input  logic [SEL_W-1:0]  shadow_sel,
    output logic [DATA_W-1:0] shadow_data,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in,
    output logic              ad_n,
    output logic              cs_n,
    output logic              rd_n,
    output logic              wr_n
);
    localparam int T_MAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                               : ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam logic [CNT_W-1:0] T_SETUP_C = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] T_PULSE_C = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] T_HOLD_C  = CNT_W'(T_HOLD - 1);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_REGS - 1);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic                write_q, write_d, burst_q, burst_d, pending_q, pending_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [2:0]          irq_sync_q, irq_sync_d;
    logic                ad_n_q, ad_n_d, cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic                ad_oe_q, ad_oe_d, ready_q, ready_d, rsp_valid_q, rsp_valid_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   ad_out_q, ad_out_d, rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0]   shadow_q [N_REGS];
    logic                refresh_req_s, refresh_now_s, shadow_we_s;

    function automatic logic [ADDR_W-1:0] list_addr(input logic [SEL_W-1:0] i);
        return ADDR_LIST[int'(i)*ADDR_W +: ADDR_W];
    endfunction

    assign irq_sync_d    = {irq_sync_q[1:0], irq};
    assign refresh_req_s = refresh_start | (irq_sync_q[1] & ~irq_sync_q[2] & irq_refresh_en);
    assign refresh_now_s = pending_q | refresh_req_s;
    // A refresh request arriving this very cycle withdraws ready so the host cannot slip in ahead of it.
    assign req_ready     = ready_q & ~refresh_req_s;

    // Transaction sequencer: phase timing, burst indexing and read capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        burst_d     = burst_q;
        idx_d       = idx_q;
        rdata_d     = rdata_q;
        shadow_we_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (refresh_now_s) begin
                    state_d = A_SETUP;
                    cnt_d   = T_SETUP_C;
                    burst_d = 1'b1;
                    idx_d   = '0;
                    addr_d  = list_addr('0);
                    write_d = 1'b0;
                end else if (req_valid && req_ready) begin
                    state_d = A_SETUP;
                    cnt_d   = T_SETUP_C;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                end else begin
                    state_d = IDLE;
                end
            end
            A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    case (state_q)
                        A_SETUP: begin state_d = A_PULSE; cnt_d = T_PULSE_C; end
                        A_PULSE: begin state_d = A_HOLD;  cnt_d = T_HOLD_C;  end
                        A_HOLD:  begin state_d = D_SETUP; cnt_d = T_SETUP_C; end
                        D_SETUP: begin state_d = D_PULSE; cnt_d = T_PULSE_C; end
                        D_PULSE: begin
                            state_d = D_HOLD;
                            cnt_d   = T_HOLD_C;
                            if (!write_q) begin
                                rdata_d     = ad_in;
                                shadow_we_s = burst_q;
                            end else begin
                                rdata_d = rdata_q;
                            end
                        end
                        default: begin state_d = GAP; cnt_d = '0; end
                    endcase
                end
            end
            GAP: begin
                if (burst_q && (idx_q != LAST_IDX)) begin
                    state_d = A_SETUP;
                    cnt_d   = T_SETUP_C;
                    idx_d   = idx_q + SEL_W'(1);
                    addr_d  = list_addr(idx_q + SEL_W'(1));
                end else begin
                    state_d = IDLE;
                    burst_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending flag: cleared as a burst launches, re-armed by anything arriving during it.
    always_comb begin
        if ((state_q == IDLE) && refresh_now_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q | refresh_req_s;
        end
    end

    // Strobe and status decode from the next state so the pins change on the same edge as the state.
    always_comb begin
        ad_n_d   = 1'b1;
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;
        case (state_d)
            A_SETUP, A_PULSE, A_HOLD: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = DATA_W'(addr_d);
                wr_n_d   = (state_d != A_PULSE);
            end
            D_SETUP, D_PULSE, D_HOLD: begin
                cs_n_d = 1'b0;
                if (write_d) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                    wr_n_d   = (state_d != D_PULSE);
                end else begin
                    rd_n_d   = (state_d != D_PULSE);
                end
            end
            default: ad_oe_d = 1'b0;
        endcase
        rsp_valid_d = (state_d == GAP) && !burst_d;
        done_d      = (state_d == GAP) && burst_d && (idx_d == LAST_IDX);
        ready_d     = (state_d == IDLE) && !pending_d;
        if ((state_q == D_HOLD) && (state_d == GAP) && !burst_q && !write_q) begin
            rsp_rdata_d = rdata_q;
        end else begin
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            write_q     <= 1'b0;
            burst_q     <= 1'b0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            irq_sync_q  <= 3'b000;
            ad_n_q      <= 1'b1;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            write_q     <= write_d;
            burst_q     <= burst_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            irq_sync_q  <= irq_sync_d;
            ad_n_q      <= ad_n_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            ad_oe_q     <= ad_oe_d;
            ad_out_q    <= ad_out_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            done_q      <= done_d;
        end
    end

    // Shadow file, written at read-capture time during refresh bursts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) shadow_q[i] <= '0;
        end else if (shadow_we_s) begin
            shadow_q[idx_q] <= ad_in;
        end
    end

    // Display-side read port.
    always_comb begin
        if (32'(shadow_sel) < N_REGS) begin
            shadow_data = shadow_q[shadow_sel];
        end else begin
            shadow_data = '0;
        end
    end

    assign ad_n         = ad_n_q;
    assign cs_n         = cs_n_q;
    assign rd_n         = rd_n_q;
    assign wr_n         = wr_n_q;
    assign ad_oe        = ad_oe_q;
    assign ad_out       = ad_out_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign refresh_busy = burst_q;
    assign refresh_done = done_q;
endmodule

// File: tb/tb_rtc_bus_master.sv
// Self-checking bench for rtc_bus_master: default instance plus a variant-timing instance,
// with a bus model answering reads and a queue of expected read/shadow values.
module tb_rtc_bus_master;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0, req_write = 1'b0, refresh_start = 1'b0, irq = 1'b0, irq_refresh_en = 1'b0;
    logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
    logic [3:0] shadow_sel = 4'd0;
    logic       req_ready, rsp_valid, refresh_busy, refresh_done, ad_oe, ad_n, cs_n, rd_n, wr_n;
    logic [7:0] rsp_rdata, shadow_data, ad_out, ad_in;

    logic       v_req_valid = 1'b0, v_refresh = 1'b0;
    logic [1:0] v_sel = 2'd0;
    logic       v_req_ready, v_rsp_valid, v_busy, v_done, v_oe, v_ad_n, v_cs_n, v_rd_n, v_wr_n;
    logic [7:0] v_rsp_rdata, v_shadow, v_ad_out, v_ad_in;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_hold = 8'h00;
    logic [7:0] addr_list [9] = '{8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};

    // RTC device model: latch the address phase, answer reads with 0x17 or address+1.
    logic [7:0] bus_addr = 8'h00, v_bus_addr = 8'h00;
    logic       bus_fixed = 1'b1;
    always @(posedge clk) if (!ad_n && ad_oe) bus_addr <= ad_out;
    always @(posedge clk) if (!v_ad_n && v_oe) v_bus_addr <= v_ad_out;
    assign ad_in   = bus_fixed ? 8'h17 : bus_addr + 8'h01;
    assign v_ad_in = v_bus_addr + 8'h01;

    rtc_bus_master dut (
        .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .refresh_start(refresh_start),
        .irq(irq), .irq_refresh_en(irq_refresh_en), .refresh_busy(refresh_busy),
        .refresh_done(refresh_done), .shadow_sel(shadow_sel), .shadow_data(shadow_data),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .ad_n(ad_n), .cs_n(cs_n),
        .rd_n(rd_n), .wr_n(wr_n)
    );

    rtc_bus_master #(.N_REGS(3), .ADDR_LIST(24'h21_22_23), .T_SETUP(2), .T_PULSE(3), .T_HOLD(2)) dut_v (
        .clock(clk), .reset(reset), .req_valid(v_req_valid), .req_ready(v_req_ready),
        .req_write(1'b1), .req_addr(8'h30), .req_wdata(8'h99),
        .rsp_valid(v_rsp_valid), .rsp_rdata(v_rsp_rdata), .refresh_start(v_refresh),
        .irq(1'b0), .irq_refresh_en(1'b0), .refresh_busy(v_busy),
        .refresh_done(v_done), .shadow_sel(v_sel), .shadow_data(v_shadow),
        .ad_out(v_ad_out), .ad_oe(v_oe), .ad_in(v_ad_in), .ad_n(v_ad_n), .cs_n(v_cs_n),
        .rd_n(v_rd_n), .wr_n(v_wr_n)
    );

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({ad_n, cs_n, rd_n, wr_n, ad_oe} !== 5'b11110) begin errors++; $display("FAIL reset_in_strobes: got %b want 11110", {ad_n, cs_n, rd_n, wr_n, ad_oe}); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if ({ad_n, cs_n, rd_n, wr_n, ad_oe} !== 5'b11110) begin errors++; $display("FAIL reset_strobes: got %b want 11110", {ad_n, cs_n, rd_n, wr_n, ad_oe}); end
        checks++; if ({ad_out, rsp_rdata} !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", {ad_out, rsp_rdata}); end
        checks++; if ({rsp_valid, refresh_busy, refresh_done} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {rsp_valid, refresh_busy, refresh_done}); end
        for (int i = 0; i < 9; i++) begin
            shadow_sel = 4'(i); #1;
            checks++; if (shadow_data !== 8'h00) begin errors++; $display("FAIL reset_shadow[%0d]: got %h want 00", i, shadow_data); end
        end
    endtask

    task automatic test_host_txn(input logic wr, input logic [7:0] a, input logic [7:0] wd);
        logic       e_adn, e_csn, e_wrn, e_rdn, e_oe;
        logic [7:0] e_out, e_rd;
        @(negedge clk);
        bus_fixed = 1'b1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL host_ready_idle: got %b want 1", req_ready); end
        if (!wr) begin exp_q.push_back(8'h17); exp_hold = 8'h17; end
        @(posedge clk); #1 req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            e_adn = !(k <= 4);
            e_csn = !(k <= 8);
            e_wrn = !((k == 2) || (k == 3) || (wr && ((k == 6) || (k == 7))));
            e_rdn = !(!wr && ((k == 6) || (k == 7)));
            e_oe  = (k <= 4) || (wr && (k >= 5) && (k <= 8));
            e_out = (k <= 4) ? a : ((wr && (k >= 5) && (k <= 8)) ? wd : 8'h00);
            checks++; if ({ad_n, cs_n, wr_n, rd_n, ad_oe} !== {e_adn, e_csn, e_wrn, e_rdn, e_oe}) begin errors++; $display("FAIL host_strobes cyc%0d: got %b want %b", k, {ad_n, cs_n, wr_n, rd_n, ad_oe}, {e_adn, e_csn, e_wrn, e_rdn, e_oe}); end
            checks++; if (ad_out !== e_out) begin errors++; $display("FAIL host_ad_out cyc%0d: got %h want %h", k, ad_out, e_out); end
            checks++; if (rsp_valid !== (k == 9)) begin errors++; $display("FAIL host_rsp_valid cyc%0d: got %b want %b", k, rsp_valid, (k == 9)); end
            if (rsp_valid && !wr) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL host_rdata: got %h want nothing queued", rsp_rdata); end
                else begin e_rd = exp_q.pop_front(); if (rsp_rdata !== e_rd) begin errors++; $display("FAIL host_rdata: got %h want %h", rsp_rdata, e_rd); end end
            end
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL host_ready_return: got %b want 1", req_ready); end
        checks++; if (rsp_rdata !== exp_hold) begin errors++; $display("FAIL host_rdata_hold: got %h want %h", rsp_rdata, exp_hold); end
    endtask

    task automatic test_refresh();
        int done_cyc = -1, done_n = 0, rv_seen = 0, busy_bad = 0;
        logic [7:0] e;
        bus_fixed = 1'b0;
        for (int i = 0; i < 9; i++) exp_q.push_back(addr_list[i] + 8'h01);
        @(negedge clk); refresh_start = 1'b1; #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL refresh_ready_gate: got %b want 0", req_ready); end
        @(posedge clk); #1 refresh_start = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (refresh_done) begin done_n++; if (done_cyc < 0) done_cyc = k; end
            if (rsp_valid) rv_seen++;
            if (refresh_busy !== (k <= 81)) busy_bad++;
        end
        checks++; if (done_cyc != 81 || done_n != 1) begin errors++; $display("FAIL refresh_done: got cycle %0d count %0d want 81 count 1", done_cyc, done_n); end
        checks++; if (rv_seen != 0) begin errors++; $display("FAIL refresh_no_rsp: got %0d pulses want 0", rv_seen); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL refresh_busy: got %0d wrong cycles want 0", busy_bad); end
        for (int i = 0; i < 9; i++) begin
            shadow_sel = 4'(i); #1;
            e = exp_q.pop_front();
            checks++; if (shadow_data !== e) begin errors++; $display("FAIL shadow[%0d]: got %h want %h", i, shadow_data, e); end
        end
        shadow_sel = 4'd9; #1;
        checks++; if (shadow_data !== 8'h00) begin errors++; $display("FAIL shadow_oor9: got %h want 00", shadow_data); end
        shadow_sel = 4'd15; #1;
        checks++; if (shadow_data !== 8'h00) begin errors++; $display("FAIL shadow_oor15: got %h want 00", shadow_data); end
        shadow_sel = 4'd0;
    endtask

    task automatic test_priority();
        int accept = -1, rsp_cyc = -1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h30; req_wdata = 8'hC3; refresh_start = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_cyc0: got %b want 0", req_ready); end
        @(posedge clk); #1 refresh_start = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_cyc < 0) rsp_cyc = k;
            if (req_ready && req_valid && accept < 0) begin
                accept = k;
                @(posedge clk); #1 req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        checks++; if (accept != 82) begin errors++; $display("FAIL prio_accept: got cycle %0d want 82", accept); end
        checks++; if (rsp_cyc != 91) begin errors++; $display("FAIL prio_rsp: got cycle %0d want 91", rsp_cyc); end
    endtask

    task automatic test_irq();
        int dones = 0, first_busy = -1;
        irq_refresh_en = 1'b1; irq = 1'b0;
        repeat (4) @(negedge clk);
        refresh_start = 1'b1;
        @(posedge clk); #1 refresh_start = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (refresh_done) dones++;
            if (k == 20) irq = 1'b1;
            if (k == 30) refresh_start = 1'b1;
            if (k == 31) refresh_start = 1'b0;
        end
        checks++; if (dones != 2) begin errors++; $display("FAIL irq_one_more_burst: got %0d bursts want 2", dones); end
        irq = 1'b0; irq_refresh_en = 1'b0; dones = 0;
        repeat (5) @(negedge clk);
        refresh_start = 1'b1;
        @(posedge clk); #1 refresh_start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (refresh_done) dones++;
            if (k == 20) irq = 1'b1;
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL irq_disabled: got %0d bursts want 1", dones); end
        irq = 1'b0; dones = 0;
        repeat (5) @(negedge clk);
        irq_refresh_en = 1'b1;
        irq = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (refresh_busy && first_busy < 0) first_busy = k;
            if (refresh_done) dones++;
        end
        checks++; if (first_busy != 3 || dones != 1) begin errors++; $display("FAIL irq_latency: got busy cycle %0d bursts %0d want 3 and 1", first_busy, dones); end
        irq = 1'b0; irq_refresh_en = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h21; req_wdata = 8'hA5;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if ({wr_n, ad_oe} !== 2'b01) begin errors++; $display("FAIL rstmid_in_dpulse: got %b want 01", {wr_n, ad_oe}); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({ad_n, cs_n, rd_n, wr_n, ad_oe} !== 5'b11110) begin errors++; $display("FAIL rstmid_strobes: got %b want 11110", {ad_n, cs_n, rd_n, wr_n, ad_oe}); end
        shadow_sel = 4'd0; #1;
        checks++; if (shadow_data !== 8'h00) begin errors++; $display("FAIL rstmid_shadow: got %h want 00", shadow_data); end
        @(negedge clk); reset = 1'b0;
        exp_hold = 8'h00;
    endtask

    task automatic test_variant();
        int done_cyc = -1, rsp_cyc = -1;
        logic [7:0] e;
        exp_q.push_back(8'h24); exp_q.push_back(8'h23); exp_q.push_back(8'h22);
        @(negedge clk); v_refresh = 1'b1;
        @(posedge clk); #1 v_refresh = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (v_done && done_cyc < 0) done_cyc = k;
        end
        checks++; if (done_cyc != 45) begin errors++; $display("FAIL variant_burst: got cycle %0d want 45", done_cyc); end
        for (int i = 0; i < 3; i++) begin
            v_sel = 2'(i); #1;
            e = exp_q.pop_front();
            checks++; if (v_shadow !== e) begin errors++; $display("FAIL variant_shadow[%0d]: got %h want %h", i, v_shadow, e); end
        end
        v_sel = 2'd3; #1;
        checks++; if (v_shadow !== 8'h00) begin errors++; $display("FAIL variant_shadow_oor: got %h want 00", v_shadow); end
        @(negedge clk); v_req_valid = 1'b1;
        @(posedge clk); #1 v_req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (v_rsp_valid && rsp_cyc < 0) rsp_cyc = k;
        end
        checks++; if (rsp_cyc != 15) begin errors++; $display("FAIL variant_txn_len: got cycle %0d want 15", rsp_cyc); end
    endtask

    initial begin
        test_reset();
        test_host_txn(1'b0, 8'h24, 8'h00);
        test_host_txn(1'b1, 8'h21, 8'h5A);
        test_refresh();
        test_priority();
        test_irq();
        test_reset_mid();
        test_host_txn(1'b0, 8'h55, 8'h00);
        test_variant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
